ysyx_23060286_imm_enc: RTL and testbench

Pipelined immediate encoder: the inverse of the immediate generator. It takes a base instruction word, an immediate type and a 32-bit immediate value, and writes the immediate back into the type's scattered instruction fields, with range and alignment checking. It sits between the self-test instruction generator and the IMEM write port. It is also the reference packer for decoder round-trip checks.

---
 rtl/ysyx_23060286_imm_enc_pkg.sv | 29 ++
 rtl/ysyx_23060286_imm_pack.sv | 50 +++++
 rtl/ysyx_23060286_imm_enc.sv | 92 +++++++++
 tb/tb_ysyx_23060286_imm_enc.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_23060286_imm_enc_pkg.sv
// Shared immediate-type codes and encoder record types; the immediate generator imports the same codes.
// No logic of its own; the helper below is a pure range check.
package ysyx_23060286_imm_enc_pkg;

  localparam logic [2:0] IMM_I = 3'b100;
  localparam logic [2:0] IMM_S = 3'b101;
  localparam logic [2:0] IMM_B = 3'b011;
  localparam logic [2:0] IMM_U = 3'b001;
  localparam logic [2:0] IMM_J = 3'b010;

  typedef struct packed {
    logic [31:0] base;
    logic [2:0]  immtype;
    logic [31:0] imm;
  } enc_req_t;

  typedef struct packed {
    logic [31:0] inst;
    logic        err;
  } enc_res_t;

  // True when imm[31:msb] are all equal, i.e. imm fits a signed (msb+1)-bit field.
  function automatic logic sext_fits(input logic [31:0] imm, input int unsigned msb);
    logic [31:0] hi;
    hi = 32'($signed(imm) >>> msb);
    return (hi == 32'h0) || (hi == 32'hFFFF_FFFF);
  endfunction

endpackage

// File: rtl/ysyx_23060286_imm_pack.sv
// Combinational immediate packer: scatters imm into the type's instruction fields and flags unrepresentable values.
// Zero latency, no handshake; invalid types return base unchanged with err set.
module ysyx_23060286_imm_pack
  import ysyx_23060286_imm_enc_pkg::*;
(
  input  logic [31:0] base,
  input  logic [2:0]  immtype,
  input  logic [31:0] imm,
  output logic [31:0] inst,
  output logic        err
);

  always_comb begin
    inst = base;
    err  = 1'b0;
    case (immtype)
      IMM_I: begin
        inst[31:20] = imm[11:0];
        err         = !sext_fits(imm, 11);
      end
      IMM_S: begin
        inst[31:25] = imm[11:5];
        inst[11:7]  = imm[4:0];
        err         = !sext_fits(imm, 11);
      end
      IMM_B: begin
        inst[31]    = imm[12];
        inst[7]     = imm[11];
        inst[30:25] = imm[10:5];
        inst[11:8]  = imm[4:1];
        err         = !sext_fits(imm, 12) || imm[0];
      end
      IMM_U: begin
        inst[31:12] = imm[31:12];
        err         = |imm[11:0];
      end
      IMM_J: begin
        inst[31]    = imm[20];
        inst[19:12] = imm[19:12];
        inst[20]    = imm[11];
        inst[30:21] = imm[10:1];
        err         = !sext_fits(imm, 20) || imm[0];
      end
      default: begin
        err = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/ysyx_23060286_imm_enc.sv
// Two-stage pipelined immediate encoder with saturating error counter; request to out_valid in 2 edges.
// Valid/ready both sides; each stage loads when empty or draining, so at most 2 requests are held under stall.
module ysyx_23060286_imm_enc
  import ysyx_23060286_imm_enc_pkg::*;
#(
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_base,
  input  logic [2:0]           in_immtype,
  input  logic [31:0]          in_imm,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_inst,
  output logic                 out_err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  logic                 s1_valid_q, s1_valid_d;
  enc_req_t             s1_req_q,   s1_req_d;
  logic                 s2_valid_q, s2_valid_d;
  enc_res_t             s2_res_q,   s2_res_d;
  logic [ERR_CNT_W-1:0] err_cnt_q,  err_cnt_d;

  logic     s1_load;
  logic     s2_load;
  enc_res_t pack_res;

  ysyx_23060286_imm_pack u_pack (
    .base    (s1_req_q.base),
    .immtype (s1_req_q.immtype),
    .imm     (s1_req_q.imm),
    .inst    (pack_res.inst),
    .err     (pack_res.err)
  );

  always_comb begin
    s2_load    = !s2_valid_q || out_ready;
    // Depends only on stage state and out_ready, never on in_valid.
    in_ready   = !s1_valid_q || !s2_valid_q || out_ready;
    s1_load    = in_ready;

    s1_valid_d = s1_valid_q;
    s1_req_d   = s1_req_q;
    s2_valid_d = s2_valid_q;
    s2_res_d   = s2_res_q;
    err_cnt_d  = err_cnt_q;

    if (s1_load) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_req_d = '{base: in_base, immtype: in_immtype, imm: in_imm};
      end
    end

    if (s2_load) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_res_d = pack_res;
      end
    end

    if (s2_valid_q && out_ready && s2_res_q.err && (err_cnt_q != {ERR_CNT_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_req_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_res_q   <= '0;
      err_cnt_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_req_q   <= s1_req_d;
      s2_valid_q <= s2_valid_d;
      s2_res_q   <= s2_res_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_inst  = s2_res_q.inst;
  assign out_err   = s2_res_q.err;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_ysyx_23060286_imm_enc.sv
// Directed bench for the immediate encoder: vector table, streaming, backpressure, reset mid-stall, saturation.
module tb_ysyx_23060286_imm_enc;
  import ysyx_23060286_imm_enc_pkg::*;

  typedef struct {
    logic [31:0] base;
    logic [2:0]  t;
    logic [31:0] imm;
    logic [31:0] inst;
    logic        err;
  } vec_t;

  localparam int NV = 13;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_base = '0;
  logic [2:0]  in_immtype = '0;
  logic [31:0] in_imm = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_inst;
  logic        out_err;
  logic [7:0]  err_cnt;

  int   n_cmp = 0;
  int   n_bad = 0;
  vec_t vecs[NV];
  int   bpi[3];
  int   got, sent, k, vis;
  logic fire;

  ysyx_23060286_imm_enc #(.ERR_CNT_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_base    (in_base),
    .in_immtype (in_immtype),
    .in_imm     (in_imm),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_inst   (out_inst),
    .out_err    (out_err),
    .err_cnt    (err_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    in_base    = v.base;
    in_immtype = v.t;
    in_imm     = v.imm;
  endtask

  // Independent immediate generator (decoder side) for round-trip checks.
  function automatic logic [31:0] dec(input logic [31:0] i, input logic [2:0] t);
    case (t)
      IMM_I:   return {{20{i[31]}}, i[31:20]};
      IMM_S:   return {{20{i[31]}}, i[31:25], i[11:7]};
      IMM_B:   return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      IMM_U:   return {i[31:12], 12'b0};
      IMM_J:   return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: return 32'h0;
    endcase
  endfunction

  task automatic stream_err(input int n);
    sent = 0;
    got  = 0;
    out_ready  = 1'b1;
    in_immtype = 3'b111;
    for (int c = 0; c < n + 4; c++) begin
      in_valid = (sent < n);
      in_base  = 32'(c);
      if (out_valid) got++;
      fire = in_valid && in_ready;
      @(negedge clk);
      if (fire) sent++;
    end
    in_valid = 1'b0;
    chk($sformatf("sat_delivered_%0d", n), 32'(got), 32'(n));
  endtask

  initial begin
    vecs[0]  = '{32'h0000_0013, IMM_I, 32'hFFFF_F800, 32'h8000_0013, 1'b0};
    vecs[1]  = '{32'h0000_0013, IMM_I, 32'h0000_07FF, 32'h7FF0_0013, 1'b0};
    vecs[2]  = '{32'h0000_0013, IMM_I, 32'h0000_0800, 32'h8000_0013, 1'b1};
    vecs[3]  = '{32'h0000_2023, IMM_S, 32'hFFFF_FFFC, 32'hFE00_2E23, 1'b0};
    vecs[4]  = '{32'h0000_0063, IMM_B, 32'h0000_0FFE, 32'h7E00_0FE3, 1'b0};
    vecs[5]  = '{32'h0000_0063, IMM_B, 32'h0000_0FFF, 32'h7E00_0FE3, 1'b1};
    vecs[6]  = '{32'h0000_0063, IMM_B, 32'hFFFF_F000, 32'h8000_0063, 1'b0};
    vecs[7]  = '{32'h0000_0037, IMM_U, 32'h1234_5000, 32'h1234_5037, 1'b0};
    vecs[8]  = '{32'h0000_0037, IMM_U, 32'h1234_5001, 32'h1234_5037, 1'b1};
    vecs[9]  = '{32'h0000_006F, IMM_J, 32'h0010_0000, 32'h8000_006F, 1'b1};
    vecs[10] = '{32'h0000_006F, IMM_J, 32'h000F_FFFE, 32'h7FFF_F06F, 1'b0};
    vecs[11] = '{32'hDEAD_BEEF, 3'b111, 32'h0000_0000, 32'hDEAD_BEEF, 1'b1};
    vecs[12] = '{32'h1234_5678, 3'b000, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1};
    bpi = '{0, 4, 10};

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_inst", out_inst, 0);
    chk("rst_out_err", out_err, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;
    out_ready = 1'b1;

    // One request at a time: latency and packing
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i]);
      in_valid = 1'b1;
      chk($sformatf("v%0d_in_ready", i), in_ready, 1);
      @(negedge clk);
      in_valid = 1'b0;
      chk($sformatf("v%0d_early_valid", i), out_valid, 0);
      @(negedge clk);
      chk($sformatf("v%0d_valid", i), out_valid, 1);
      chk($sformatf("v%0d_inst", i), out_inst, vecs[i].inst);
      chk($sformatf("v%0d_err", i), out_err, vecs[i].err);
      if (!vecs[i].err) chk($sformatf("v%0d_roundtrip", i), dec(out_inst, vecs[i].t), vecs[i].imm);
      @(negedge clk);
    end
    chk("err_cnt_after_table", err_cnt, 6);

    // Back-to-back stream: one result per cycle
    got = 0;
    sent = 0;
    for (int c = 0; c < NV + 2; c++) begin
      if (sent < NV) begin
        drive(vecs[sent]);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      if (out_valid && got < NV) begin
        chk($sformatf("st%0d_inst", got), out_inst, vecs[got].inst);
        chk($sformatf("st%0d_err", got), out_err, vecs[got].err);
        got++;
      end
      fire = in_valid && in_ready;
      @(negedge clk);
      if (fire) sent++;
    end
    in_valid = 1'b0;
    chk("stream_count", 32'(got), 32'(NV));
    chk("err_cnt_after_stream", err_cnt, 12);

    // Backpressure: 3 requests offered, only 2 fit
    out_ready = 1'b0;
    k = 0;
    for (int c = 0; c < 6; c++) begin
      if (k < 3) begin
        drive(vecs[bpi[k]]);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      if (out_valid) chk($sformatf("bp_hold_inst_c%0d", c), out_inst, vecs[bpi[0]].inst);
      fire = in_valid && in_ready;
      @(negedge clk);
      if (fire) k++;
    end
    chk("bp_accepted", 32'(k), 2);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_out_valid", out_valid, 1);
    chk("bp_err_cnt", err_cnt, 12);

    out_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 8; c++) begin
      if (k < 3) begin
        drive(vecs[bpi[k]]);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      if (out_valid && got < 3) begin
        chk($sformatf("bp_drain%0d_inst", got), out_inst, vecs[bpi[got]].inst);
        chk($sformatf("bp_drain%0d_rt", got), dec(out_inst, vecs[bpi[got]].t), vecs[bpi[got]].imm);
        got++;
      end
      fire = in_valid && in_ready;
      @(negedge clk);
      if (fire) k++;
    end
    in_valid = 1'b0;
    chk("bp_drained", 32'(got), 3);
    chk("bp_all_sent", 32'(k), 3);

    // Reset while stalled with two erroneous requests in flight
    out_ready = 1'b0;
    k = 0;
    for (int c = 0; c < 3; c++) begin
      drive(vecs[11 + (k % 2)]);
      in_valid = (k < 2);
      fire = in_valid && in_ready;
      @(negedge clk);
      if (fire) k++;
    end
    in_valid = 1'b0;
    chk("mid_stall_inflight", 32'(k), 2);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_err_cnt", err_cnt, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_out_inst", out_inst, 0);
    out_ready = 1'b1;
    vis = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (out_valid) vis++;
    end
    chk("mid_rst_dropped", 32'(vis), 0);

    // Counter saturation: 254 then 46 more erroneous transfers
    stream_err(254);
    chk("sat_cnt_254", err_cnt, 254);
    stream_err(46);
    chk("sat_cnt_300", err_cnt, 255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
